// File: rtl/gate_op_arbiter.sv
// Four-requester round-robin arbiter feeding a single registered bitwise-logic unit.
// The output register accepts a new request while empty or while its current result is being consumed.
module gate_op_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req_valid,
  output logic [3:0]         req_ready,
  input  logic [11:0]        req_op,
  input  logic [4*WIDTH-1:0] req_a,
  input  logic [4*WIDTH-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_y,
  output logic [1:0]         rsp_id,
  output logic               rsp_err
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_r, state_nxt_s;
  logic [1:0]       rr_ptr_r;
  logic [1:0]       idx_s;
  logic [1:0]       win_s;
  logic [31:0]      win_i_s;
  logic             found_s;
  logic             load_en_s;
  logic             accept_s;
  logic [2:0]       win_op_s;
  logic [WIDTH-1:0] win_a_s;
  logic [WIDTH-1:0] win_b_s;
  logic [WIDTH-1:0] y_r;
  logic [1:0]       id_r;
  logic             err_r;

  function automatic logic [WIDTH-1:0] gate_eval(input logic [2:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    case (op)
      3'b000:  gate_eval = a & b;
      3'b001:  gate_eval = a | b;
      3'b010:  gate_eval = ~(a & b);
      3'b011:  gate_eval = ~(a | b);
      3'b100:  gate_eval = a ^ b;
      3'b101:  gate_eval = ~(a ^ b);
      default: gate_eval = {WIDTH{1'b0}};
    endcase
  endfunction

  function automatic logic op_illegal(input logic [2:0] op);
    op_illegal = (op[2:1] == 2'b11);
  endfunction

  // Round-robin winner search and combinational grant; rst_n gates the grant so nothing is offered in reset.
  always_comb begin
    found_s = 1'b0;
    win_s   = rr_ptr_r;
    idx_s   = rr_ptr_r;
    for (int k = 0; k < 4; k++) begin
      idx_s = rr_ptr_r + k[1:0];
      if (!found_s && req_valid[idx_s]) begin
        found_s = 1'b1;
        win_s   = idx_s;
      end else begin
        found_s = found_s;
      end
    end
    load_en_s = (state_r == EMPTY) || rsp_ready;
    accept_s  = rst_n && load_en_s && found_s;
    req_ready = accept_s ? (4'b0001 << win_s) : 4'b0000;
    win_i_s   = {30'd0, win_s};
    win_op_s  = req_op[win_i_s*32'd3 +: 3];
    win_a_s   = req_a[win_i_s*WIDTH +: WIDTH];
    win_b_s   = req_b[win_i_s*WIDTH +: WIDTH];
  end

  // Output-register occupancy: a grant always fills it, a consume without a grant empties it.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      EMPTY:   state_nxt_s = accept_s ? FULL : EMPTY;
      FULL: begin
        if (accept_s) begin
          state_nxt_s = FULL;
        end else if (rsp_ready) begin
          state_nxt_s = EMPTY;
        end else begin
          state_nxt_s = FULL;
        end
      end
      default: state_nxt_s = EMPTY;
    endcase
  end

  // State, pointer and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= EMPTY;
      rr_ptr_r <= 2'd0;
      y_r      <= {WIDTH{1'b0}};
      id_r     <= 2'd0;
      err_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        rr_ptr_r <= win_s + 2'd1;
        y_r      <= gate_eval(win_op_s, win_a_s, win_b_s);
        id_r     <= win_s;
        err_r    <= op_illegal(win_op_s);
      end else begin
        rr_ptr_r <= rr_ptr_r;
        y_r      <= y_r;
        id_r     <= id_r;
        err_r    <= err_r;
      end
    end
  end

  assign rsp_valid = (state_r == FULL);
  assign rsp_y     = y_r;
  assign rsp_id    = id_r;
  assign rsp_err   = err_r;

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Directed-vector bench for gate_op_arbiter: opcodes, round-robin order, backpressure and async reset.
module tb_gate_op_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [11:0] req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_y;
  logic [1:0]  rsp_id;
  logic        rsp_err;

  int n_vec = 0;
  int n_bad = 0;

  gate_op_arbiter #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] op_exp [8];
  logic [7:0] rr_exp [4];
  logic [3:0] rdy_exp;

  initial begin
    op_exp = '{8'h05, 8'hAF, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'h00, 8'h00};
    rr_exp = '{8'h11, 8'h22, 8'h33, 8'h44};

    rst_n = 1'b0; req_valid = 4'b1111; req_op = 12'h000;
    req_a = 32'h0; req_b = 32'h0; rsp_ready = 1'b0;
    #12;
    check("rst_ready", req_ready, 4'b0000);
    check("rst_valid", rsp_valid, 1'b0);
    check("rst_y", rsp_y, 8'h00);
    check("rst_id", rsp_id, 2'd0);
    check("rst_err", rsp_err, 1'b0);

    // Basic AND from requester 0.
    @(negedge clk);
    rst_n = 1'b1; req_valid = 4'b0001; req_op = 12'h000;
    req_a = 32'h0000_00F0; req_b = 32'h0000_003C; rsp_ready = 1'b1;
    #1 check("and_ready", req_ready, 4'b0001);
    @(posedge clk); #1;
    check("and_valid", rsp_valid, 1'b1);
    check("and_y", rsp_y, 8'h30);
    check("and_id", rsp_id, 2'd0);
    check("and_err", rsp_err, 1'b0);

    // Every opcode, back-to-back from requester 0.
    for (int op = 0; op < 8; op++) begin
      @(negedge clk);
      req_op[2:0] = op[2:0]; req_a[7:0] = 8'hA5; req_b[7:0] = 8'h0F;
      #1 check("op_ready", req_ready, 4'b0001);
      @(posedge clk); #1;
      check("op_valid", rsp_valid, 1'b1);
      check("op_y", rsp_y, op_exp[op]);
      check("op_err", rsp_err, (op >= 6) ? 1'b1 : 1'b0);
    end

    // Pointer sits at 1, so requester 2 wins alone.
    @(negedge clk);
    req_valid = 4'b0100; req_op[8:6] = 3'b001; req_a[23:16] = 8'hA5; req_b[23:16] = 8'h0F;
    #1 check("r2_ready", req_ready, 4'b0100);
    @(posedge clk); #1;
    check("r2_y", rsp_y, 8'hAF);
    check("r2_id", rsp_id, 2'd2);

    // Asynchronous reset while a result is pending.
    @(negedge clk);
    rst_n = 1'b0; req_valid = 4'b1111;
    #1;
    check("arst_valid", rsp_valid, 1'b0);
    check("arst_y", rsp_y, 8'h00);
    check("arst_id", rsp_id, 2'd0);
    check("arst_err", rsp_err, 1'b0);
    check("arst_ready", req_ready, 4'b0000);

    @(negedge clk);
    rst_n = 1'b1; req_op = 12'h000;
    req_a = 32'hFFFF_FFFF; req_b = 32'h4433_2211;
    #1 check("rr_first_ready", req_ready, 4'b0001);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("rr_valid", rsp_valid, 1'b1);
      check("rr_id", rsp_id, i % 4);
      check("rr_y", rsp_y, rr_exp[i % 4]);
      rdy_exp = 4'b0001 << ((i + 1) % 4);
      check("rr_ready", req_ready, rdy_exp);
    end

    // Backpressure: holding requester 3's result, requester 1 must wait.
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_ready", req_ready, 4'b0000);
      @(posedge clk); #1;
      check("bp_valid", rsp_valid, 1'b1);
      check("bp_id", rsp_id, 2'd3);
      check("bp_y", rsp_y, 8'h44);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1 check("bp_release_ready", req_ready, 4'b0010);
    @(posedge clk); #1;
    check("bp_next_valid", rsp_valid, 1'b1);
    check("bp_next_id", rsp_id, 2'd1);
    check("bp_next_y", rsp_y, 8'h22);

    // Drain: register empties and keeps the last result.
    @(negedge clk);
    req_valid = 4'b0000;
    #1 check("drain_ready", req_ready, 4'b0000);
    @(posedge clk); #1;
    check("drain_valid", rsp_valid, 1'b0);
    check("drain_y_hold", rsp_y, 8'h22);
    check("drain_id_hold", rsp_id, 2'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
